// File: rtl/alu_control_if.sv
// Handshake bundle between the ID/EX register, the ALU control pipe and the
// execute stage. The block itself uses the slave view.
interface alu_control_if #(
  parameter int SEL_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [5:0]       funct;
  logic [1:0]       aluop;
  logic [SEL_W-1:0] select;
  logic             out_valid;
  logic             out_ready;
  logic             illegal;
  logic             mdu_start;
  logic [1:0]       mdu_op;
  logic             busy;

  modport slave (
    input  in_valid, funct, aluop, out_ready,
    output in_ready, select, out_valid, illegal, mdu_start, mdu_op, busy
  );

  modport master (
    output in_valid, funct, aluop, out_ready,
    input  in_ready, select, out_valid, illegal, mdu_start, mdu_op, busy
  );
endinterface

// File: rtl/alu_control_pipe.sv
// Registered ALU control decoder with valid/ready handshake on both sides.
// Multiply/divide ops launch the MDU and hold the result slot until the
// configured latency has elapsed, then hand off select=MDU downstream.
module alu_control_pipe #(
  parameter int SEL_W   = 4,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_control_if.slave   bus
);

  localparam logic [3:0] ENC_AND  = 4'b0000;
  localparam logic [3:0] ENC_OR   = 4'b0001;
  localparam logic [3:0] ENC_ADD  = 4'b0010;
  localparam logic [3:0] ENC_XOR  = 4'b0011;
  localparam logic [3:0] ENC_NOR  = 4'b0100;
  localparam logic [3:0] ENC_SUB  = 4'b0110;
  localparam logic [3:0] ENC_SLT  = 4'b0111;
  localparam logic [3:0] ENC_SLTU = 4'b1000;
  localparam logic [3:0] ENC_SLL  = 4'b1001;
  localparam logic [3:0] ENC_SRL  = 4'b1010;
  localparam logic [3:0] ENC_SRA  = 4'b1011;
  localparam logic [3:0] ENC_MDU  = 4'b1100;
  localparam logic [3:0] ENC_X    = 4'b1111;

  // Counter preload is LAT-1; the mdu_start cycle itself does not count down,
  // which places out_valid LAT+1 cycles after the accept edge.
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

  typedef enum logic [1:0] {IDLE, OUT, MDU} state_t;

  typedef struct packed {
    logic [3:0] sel;
    logic       ill;
    logic       mdu;
  } dec_t;

  function automatic dec_t decode(input logic [1:0] op, input logic [5:0] f);
    dec_t d;
    d.sel = ENC_X;
    d.ill = 1'b1;
    d.mdu = 1'b0;
    case (op)
      2'b00: begin d.sel = ENC_ADD; d.ill = 1'b0; end
      2'b01: begin d.sel = ENC_SUB; d.ill = 1'b0; end
      2'b10: begin
        d.ill = 1'b0;
        case (f)
          6'b100000, 6'b100001: d.sel = ENC_ADD;
          6'b100010, 6'b100011: d.sel = ENC_SUB;
          6'b100100: d.sel = ENC_AND;
          6'b100101: d.sel = ENC_OR;
          6'b100110: d.sel = ENC_XOR;
          6'b100111: d.sel = ENC_NOR;
          6'b101010: d.sel = ENC_SLT;
          6'b101011: d.sel = ENC_SLTU;
          6'b000000: d.sel = ENC_SLL;
          6'b000010: d.sel = ENC_SRL;
          6'b000011: d.sel = ENC_SRA;
          6'b011000, 6'b011001, 6'b011010, 6'b011011: begin
            d.sel = ENC_MDU;
            d.mdu = 1'b1;
          end
          default: begin d.sel = ENC_X; d.ill = 1'b1; end
        endcase
      end
      default: begin d.sel = ENC_X; d.ill = 1'b1; end
    endcase
    return d;
  endfunction

  state_t           state, state_nx;
  logic [SEL_W-1:0] select_p1, select_nx;
  logic             illegal_p1, illegal_nx;
  logic             vld_p1, vld_nx;
  logic             start_p1, start_nx;
  logic [1:0]       mdu_op_p1, mdu_op_nx;
  logic [CNT_W-1:0] cnt_p1, cnt_nx;
  logic             accept, handoff;
  dec_t             dec;

  assign dec          = decode(bus.aluop, bus.funct);
  assign bus.in_ready = (state == IDLE) || ((state == OUT) && bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign handoff      = vld_p1 && bus.out_ready;

  assign bus.select    = select_p1;
  assign bus.illegal   = illegal_p1;
  assign bus.out_valid = vld_p1;
  assign bus.mdu_start = start_p1;
  assign bus.mdu_op    = mdu_op_p1;
  assign bus.busy      = (state == MDU);

  // State and output registers; reset aborts any in-flight MDU op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      select_p1  <= '0;
      illegal_p1 <= 1'b0;
      vld_p1     <= 1'b0;
      start_p1   <= 1'b0;
      mdu_op_p1  <= 2'b00;
      cnt_p1     <= '0;
    end else begin
      state      <= state_nx;
      select_p1  <= select_nx;
      illegal_p1 <= illegal_nx;
      vld_p1     <= vld_nx;
      start_p1   <= start_nx;
      mdu_op_p1  <= mdu_op_nx;
      cnt_p1     <= cnt_nx;
    end
  end

  // Next-state logic: accept/handoff sequencing and MDU latency countdown.
  always_comb begin
    state_nx   = state;
    select_nx  = select_p1;
    illegal_nx = illegal_p1;
    vld_nx     = vld_p1;
    start_nx   = 1'b0;
    mdu_op_nx  = mdu_op_p1;
    cnt_nx     = cnt_p1;
    case (state)
      IDLE, OUT: begin
        if ((state == OUT) && handoff) begin
          vld_nx   = 1'b0;
          state_nx = IDLE;
        end
        if (accept) begin
          if (dec.mdu) begin
            state_nx  = MDU;
            vld_nx    = 1'b0;
            start_nx  = 1'b1;
            mdu_op_nx = bus.funct[1:0];
            cnt_nx    = bus.funct[1] ? DIV_LOAD : MUL_LOAD;
          end else begin
            state_nx   = OUT;
            vld_nx     = 1'b1;
            select_nx  = SEL_W'(dec.sel);
            illegal_nx = dec.ill;
          end
        end
      end
      MDU: begin
        if (!start_p1) begin
          if (cnt_p1 == '0) begin
            state_nx   = OUT;
            vld_nx     = 1'b1;
            select_nx  = SEL_W'(ENC_MDU);
            illegal_nx = 1'b0;
          end else begin
            cnt_nx = cnt_p1 - CNT_W'(1);
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule
